// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and write-back stage of the pipelined RV32I core.
// Issues loads/stores to the data cache over a request/response handshake,
// stalls upstream while an access is outstanding, aligns store lanes, extracts
// and extends load data, and registers the MEM/WB write-back result.

package regfilemux;
  typedef enum logic [3:0] {
    alu_out  = 4'd0,
    br_en    = 4'd1,
    u_imm    = 4'd2,
    lw       = 4'd3,
    pc_plus4 = 4'd4,
    lb       = 4'd5,
    lbu      = 4'd6,
    lh       = 4'd7,
    lhu      = 4'd8
  } regfilemux_sel_t;
endpackage

module mem_wb_stage
  import regfilemux::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_load,
  input  logic             in_store,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_alu_out,
  input  logic [31:0]      in_rs2,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_u_imm,
  input  logic             in_br_en,
  input  regfilemux_sel_t  in_regfilemux_sel,
  input  logic [4:0]       in_rd,
  input  logic             in_load_regfile,
  output logic [31:0]      dmem_address,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [3:0]       dmem_wmask,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_resp,
  output logic             stall_mem,
  output logic             misalign_err,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             wb_load_regfile,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t          r_state;
  logic [31:0]     r_dmem_address, r_dmem_wdata, r_wb_data;
  logic            r_dmem_read, r_dmem_write, r_misalign_err;
  logic [3:0]      r_dmem_wmask;
  logic            r_wb_valid, r_wb_load_regfile;
  logic [4:0]      r_wb_rd;
  logic [CNT_W-1:0] r_stall_count;

  // Instruction fields held while the access is outstanding.
  regfilemux_sel_t r_sel;
  logic [31:0]     r_alu_out, r_pc, r_u_imm;
  logic            r_br_en, r_load_regfile;
  logic [4:0]      r_rd;

  logic            w_aligned, w_mem_req, w_mem_op, w_stall;
  logic [3:0]      w_wmask;
  logic [31:0]     w_wdata;
  logic            w_unused;

  // Sign/zero choice comes from the write-back select, not funct3[2].
  assign w_unused = in_funct3[2];

  // Write-back value selection, shared by the direct and the memory paths.
  function automatic logic [31:0] f_wb_value(input regfilemux_sel_t sel,
                                             input logic [31:0] alu,
                                             input logic br,
                                             input logic [31:0] uimm,
                                             input logic [31:0] pc,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{alu[1:0], 3'b000} +: 8];
    h = alu[1] ? rdata[31:16] : rdata[15:0];
    case (sel)
      alu_out:  return alu;
      br_en:    return {31'd0, br};
      u_imm:    return uimm;
      lw:       return rdata;
      pc_plus4: return pc + 32'd4;
      lb:       return {{24{b[7]}}, b};
      lbu:      return {24'd0, b};
      lh:       return {{16{h[15]}}, h};
      lhu:      return {16'd0, h};
      default:  return 32'd0;
    endcase
  endfunction

  // Alignment check, store lane steering and the upstream stall request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_aligned = 1'b0;
    w_wmask   = 4'b0000;
    w_wdata   = in_rs2;
    case (in_funct3[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~in_alu_out[0];
      2'b10:   w_aligned = (in_alu_out[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
    if (in_store) begin
      case (in_funct3[1:0])
        2'b00: begin
          w_wmask = 4'b0001 << in_alu_out[1:0];
          w_wdata = {4{in_rs2[7:0]}};
        end
        2'b01: begin
          w_wmask = 4'b0011 << {in_alu_out[1], 1'b0};
          w_wdata = {2{in_rs2[15:0]}};
        end
        default: begin
          w_wmask = 4'b1111;
          w_wdata = in_rs2;
        end
      endcase
    end
    w_mem_req = in_valid & (in_load | in_store);
    w_mem_op  = w_mem_req & w_aligned;
    w_stall   = (r_state == ST_IDLE) ? w_mem_op : ~dmem_resp;
  end

  // Capture the instruction fields when an access is launched.
  always_ff @(posedge clk) begin
    // NOTE: datapath-only holding registers carry no reset; they are always written before ACCESS reads them.
    if (r_state == ST_IDLE && w_mem_op) begin
      r_sel          <= in_regfilemux_sel;
      r_alu_out      <= in_alu_out;
      r_pc           <= in_pc;
      r_u_imm        <= in_u_imm;
      r_br_en        <= in_br_en;
      r_rd           <= in_rd;
      r_load_regfile <= in_load_regfile;
    end
  end

  // Request FSM, MEM/WB result register, sticky error flag and stall counter.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state           <= ST_IDLE;
      r_dmem_address    <= '0;
      r_dmem_read       <= 1'b0;
      r_dmem_write      <= 1'b0;
      r_dmem_wmask      <= 4'b0000;
      r_dmem_wdata      <= '0;
      r_misalign_err    <= 1'b0;
      r_wb_valid        <= 1'b0;
      r_wb_rd           <= '0;
      r_wb_data         <= '0;
      r_wb_load_regfile <= 1'b0;
      r_stall_count     <= '0;
    end else begin
      if (w_stall) r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
      case (r_state)
        ST_IDLE: begin
          if (w_mem_op) begin
            r_state           <= ST_ACCESS;
            r_dmem_address    <= {in_alu_out[31:2], 2'b00};
            r_dmem_read       <= in_load;
            r_dmem_write      <= in_store;
            r_dmem_wmask      <= w_wmask;
            r_dmem_wdata      <= w_wdata;
            r_wb_valid        <= 1'b0;
            r_wb_load_regfile <= 1'b0;
          end else begin
            r_wb_valid        <= in_valid;
            r_wb_load_regfile <= in_valid & ~w_mem_req & in_load_regfile & (in_rd != 5'd0);
            if (in_valid) begin
              r_wb_rd   <= in_rd;
              r_wb_data <= f_wb_value(in_regfilemux_sel, in_alu_out, in_br_en,
                                      in_u_imm, in_pc, 32'd0);
            end
            if (w_mem_req) r_misalign_err <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (dmem_resp) begin
            r_state           <= ST_IDLE;
            r_dmem_read       <= 1'b0;
            r_dmem_write      <= 1'b0;
            r_dmem_wmask      <= 4'b0000;
            r_wb_valid        <= 1'b1;
            r_wb_rd           <= r_rd;
            r_wb_data         <= f_wb_value(r_sel, r_alu_out, r_br_en, r_u_imm,
                                            r_pc, dmem_rdata);
            r_wb_load_regfile <= r_load_regfile & (r_rd != 5'd0);
          end else begin
            r_wb_valid        <= 1'b0;
            r_wb_load_regfile <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall_mem       = w_stall;
  assign dmem_address    = r_dmem_address;
  assign dmem_read       = r_dmem_read;
  assign dmem_write      = r_dmem_write;
  assign dmem_wmask      = r_dmem_wmask;
  assign dmem_wdata      = r_dmem_wdata;
  assign misalign_err    = r_misalign_err;
  assign wb_valid        = r_wb_valid;
  assign wb_rd           = r_wb_rd;
  assign wb_data         = r_wb_data;
  assign wb_load_regfile = r_wb_load_regfile;
  assign stall_count     = r_stall_count;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed instruction stream, a
// behavioural model of the stage's visible effects, a per-cycle compare
// process and literal expectations for the key scenarios.
module tb_mem_wb_stage;
  import regfilemux::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0, in_load = 1'b0, in_store = 1'b0;
  logic [2:0]       in_funct3 = 3'b000;
  logic [31:0]      in_alu_out = '0, in_rs2 = '0, in_pc = '0, in_u_imm = '0;
  logic             in_br_en = 1'b0;
  regfilemux_sel_t  in_regfilemux_sel = alu_out;
  logic [4:0]       in_rd = '0;
  logic             in_load_regfile = 1'b0;
  logic [31:0]      dmem_address, dmem_wdata;
  logic             dmem_read, dmem_write;
  logic [3:0]       dmem_wmask;
  logic [31:0]      dmem_rdata = 32'hDEAD_BEEF;
  logic             dmem_resp = 1'b0;
  logic             stall_mem, misalign_err, wb_valid, wb_load_regfile;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic [31:0]      stall_count;

  mem_wb_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
    .in_funct3(in_funct3), .in_alu_out(in_alu_out), .in_rs2(in_rs2),
    .in_pc(in_pc), .in_u_imm(in_u_imm), .in_br_en(in_br_en),
    .in_regfilemux_sel(in_regfilemux_sel), .in_rd(in_rd),
    .in_load_regfile(in_load_regfile),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall_mem(stall_mem), .misalign_err(misalign_err),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_load_regfile(wb_load_regfile), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            load, store;
    logic [2:0]      f3;
    logic [31:0]     alu, rs2, pc, uimm;
    logic            br;
    regfilemux_sel_t sel;
    logic [4:0]      rd;
    logic            lrf;
    int              lat;
    logic [31:0]     rdata;
  } instr_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_aligned(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned size;
    size = 1 << f3[1:0];
    return (f3[1:0] != 2'b11) && ((addr % size) == 0);
  endfunction

  function automatic logic [31:0] expect_wb(input regfilemux_sel_t sel, input logic [31:0] alu,
                                            input logic br, input logic [31:0] uimm,
                                            input logic [31:0] pc, input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * (alu % 4))) & 32'hFF;
    h = (rdata >> (16 * ((alu % 4) / 2))) & 32'hFFFF;
    case (sel)
      alu_out:  return alu;
      br_en:    return br ? 32'd1 : 32'd0;
      u_imm:    return uimm;
      lw:       return rdata;
      pc_plus4: return pc + 32'd4;
      lb:       return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      lbu:      return b;
      lh:       return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      lhu:      return h;
      default:  return 32'd0;
    endcase
  endfunction

  bit          m_ready = 1'b0, m_busy = 1'b0, m_stall;
  instr_t      m_req, m_cur;
  logic        e_read, e_write, e_mis, e_wb_valid, e_wb_lrf, e_data_known;
  logic [3:0]  e_wmask;
  logic [31:0] e_addr, e_wdata, e_wb_data, e_cnt;
  logic [4:0]  e_wb_rd;

  initial begin : model
    forever begin
      @(posedge clk);
      m_cur.load = in_load;  m_cur.store = in_store; m_cur.f3 = in_funct3;
      m_cur.alu = in_alu_out; m_cur.rs2 = in_rs2; m_cur.pc = in_pc;
      m_cur.uimm = in_u_imm; m_cur.br = in_br_en; m_cur.sel = in_regfilemux_sel;
      m_cur.rd = in_rd; m_cur.lrf = in_load_regfile;
      if (rst) begin
        m_ready = 1'b1; m_busy = 1'b0;
        e_read = 0; e_write = 0; e_wmask = 0; e_addr = 0; e_wdata = 0; e_mis = 0;
        e_wb_valid = 0; e_wb_lrf = 0; e_wb_rd = 0; e_wb_data = 0; e_cnt = 0;
        e_data_known = 1'b1;
      end else begin
        m_stall = m_busy ? !dmem_resp
                         : (in_valid && (in_load || in_store) && is_aligned(in_funct3, in_alu_out));
        if (m_stall) e_cnt = e_cnt + 1;
        if (m_busy) begin
          if (dmem_resp) begin
            m_busy = 1'b0; e_read = 0; e_write = 0; e_wmask = 0;
            e_wb_valid = 1; e_wb_rd = m_req.rd; e_data_known = 1;
            e_wb_data = expect_wb(m_req.sel, m_req.alu, m_req.br, m_req.uimm, m_req.pc, dmem_rdata);
            e_wb_lrf = m_req.lrf && (m_req.rd != 0);
          end else begin
            e_wb_valid = 0; e_wb_lrf = 0;
          end
        end else if (in_valid && (in_load || in_store)) begin
          if (is_aligned(in_funct3, in_alu_out)) begin
            m_busy = 1'b1; m_req = m_cur;
            e_read = in_load; e_write = in_store;
            e_addr = in_alu_out - (in_alu_out % 4);
            e_wmask = 0; e_wdata = 0;
            if (in_store) begin
              for (int i = 0; i < 4; i++) begin
                int unsigned size, off;
                size = 1 << in_funct3[1:0];
                off  = in_alu_out % 4;
                e_wdata[8*i +: 8] = in_rs2[8*(i % size) +: 8];
                e_wmask[i] = (i >= off) && (i < off + size);
              end
            end
            e_wb_valid = 0; e_wb_lrf = 0;
          end else begin
            e_mis = 1; e_wb_valid = 1; e_wb_lrf = 0; e_wb_rd = in_rd; e_data_known = 0;
          end
        end else if (in_valid) begin
          e_wb_valid = 1; e_wb_rd = in_rd; e_data_known = 1;
          e_wb_data = expect_wb(in_regfilemux_sel, in_alu_out, in_br_en, in_u_imm, in_pc, 32'd0);
          e_wb_lrf = in_load_regfile && (in_rd != 0);
        end else begin
          e_wb_valid = 0; e_wb_lrf = 0;
        end
      end
    end
  end

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (m_ready) begin
      check("stall_mem", stall_mem,
            m_busy ? !dmem_resp
                   : (in_valid && (in_load || in_store) && is_aligned(in_funct3, in_alu_out)));
      check("dmem_read", dmem_read, e_read);
      check("dmem_write", dmem_write, e_write);
      check("misalign_err", misalign_err, e_mis);
      check("wb_valid", wb_valid, e_wb_valid);
      check("wb_load_regfile", wb_load_regfile, e_wb_lrf);
      check("stall_count", stall_count, e_cnt);
      if (e_read || e_write) begin
        check("dmem_address", dmem_address, e_addr);
        check("dmem_wmask", dmem_wmask, e_wmask);
      end else begin
        check("dmem_wmask_idle", dmem_wmask, 4'b0000);
      end
      if (e_write) check("dmem_wdata", dmem_wdata, e_wdata);
      if (e_wb_valid) begin
        check("wb_rd", wb_rd, e_wb_rd);
        if (e_data_known) check("wb_data", wb_data, e_wb_data);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic        g_read, g_write;
  logic [3:0]  g_wmask;
  logic [31:0] g_addr, g_wdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] rs2,
                                input regfilemux_sel_t sel, input logic [4:0] rd,
                                input logic lrf, input int lat, input logic [31:0] rdata);
    instr_t x;
    x.load = ld; x.store = st; x.f3 = f3; x.alu = alu; x.rs2 = rs2;
    x.pc = 32'h0000_0400; x.uimm = 32'h1234_5000; x.br = 1'b1;
    x.sel = sel; x.rd = rd; x.lrf = lrf; x.lat = lat; x.rdata = rdata;
    return x;
  endfunction

  task automatic drive(input instr_t x);
    in_valid = 1'b1; in_load = x.load; in_store = x.store; in_funct3 = x.f3;
    in_alu_out = x.alu; in_rs2 = x.rs2; in_pc = x.pc; in_u_imm = x.uimm;
    in_br_en = x.br; in_regfilemux_sel = x.sel; in_rd = x.rd; in_load_regfile = x.lrf;
  endtask

  // Present one instruction; for an aligned memory op, answer after x.lat wait cycles.
  task automatic present(input instr_t x);
    drive(x);
    if ((x.load || x.store) && is_aligned(x.f3, x.alu)) begin
      step();
      g_read = dmem_read; g_write = dmem_write; g_addr = dmem_address;
      g_wmask = dmem_wmask; g_wdata = dmem_wdata;
      repeat (x.lat) step();
      dmem_resp = 1'b1; dmem_rdata = x.rdata;
      step();
      dmem_resp = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
    end else begin
      step();
    end
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
  endtask

  instr_t x;

  initial begin
    rst = 1'b1;
    repeat (2) step();
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_rd", wb_rd, 5'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_dmem_address", dmem_address, 32'd0);
    check("rst_dmem_wdata", dmem_wdata, 32'd0);
    check("rst_stall_count", stall_count, 32'd0);
    rst = 1'b0;
    step();

    // add: alu result straight through
    present(mk(0, 0, 3'b000, 32'h10, 0, alu_out, 5'd5, 1, 0, 0));
    check("add_wb_valid", wb_valid, 1'b1);
    check("add_wb_rd", wb_rd, 5'd5);
    check("add_wb_data", wb_data, 32'h10);
    check("add_stall_count", stall_count, 32'd0);

    // lb / lbu at 0x1003, three wait cycles each
    present(mk(1, 0, 3'b000, 32'h1003, 0, lb, 5'd6, 1, 3, 32'h80FF_1234));
    check("lb_req_addr", g_addr, 32'h1000);
    check("lb_req_read", g_read, 1'b1);
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    check("lb_stall_count", stall_count, 32'd4);
    present(mk(1, 0, 3'b100, 32'h1003, 0, lbu, 5'd7, 1, 3, 32'h80FF_1234));
    check("lbu_wb_data", wb_data, 32'h0000_0080);
    check("lbu_stall_count", stall_count, 32'd8);

    // sh at 0x2002
    present(mk(0, 1, 3'b001, 32'h2002, 32'hAAAA_BEEF, alu_out, 5'd0, 0, 1, 0));
    check("sh_req_write", g_write, 1'b1);
    check("sh_req_wmask", g_wmask, 4'b1100);
    check("sh_req_wdata", g_wdata, 32'hBEEF_BEEF);
    check("sh_wb_lrf", wb_load_regfile, 1'b0);
    check("sh_stall_count", stall_count, 32'd10);

    // misaligned lw at 0x3001, then misaligned sh at 0x2001
    present(mk(1, 0, 3'b010, 32'h3001, 0, lw, 5'd8, 1, 0, 0));
    check("mis_dmem_read", dmem_read, 1'b0);
    check("mis_err", misalign_err, 1'b1);
    check("mis_wb_valid", wb_valid, 1'b1);
    check("mis_wb_lrf", wb_load_regfile, 1'b0);
    check("mis_stall_count", stall_count, 32'd10);
    present(mk(0, 1, 3'b001, 32'h2001, 32'h1111_2222, alu_out, 5'd0, 0, 0, 0));
    check("mis_sh_write", dmem_write, 1'b0);

    // other write-back selects
    present(mk(0, 0, 3'b000, 32'h0, 0, br_en, 5'd9, 1, 0, 0));
    check("br_wb_data", wb_data, 32'd1);
    present(mk(0, 0, 3'b000, 32'h0, 0, u_imm, 5'd10, 1, 0, 0));
    check("uimm_wb_data", wb_data, 32'h1234_5000);
    x = mk(0, 0, 3'b000, 32'h55, 0, alu_out, 5'd10, 1, 0, 0);
    x.sel = regfilemux_sel_t'(4'd12);
    present(x);
    check("undef_sel_wb_data", wb_data, 32'd0);

    // sb with zero wait, halfword loads back to back, sw, lw
    present(mk(0, 1, 3'b000, 32'h41, 32'h0000_00A5, alu_out, 5'd0, 0, 0, 0));
    check("sb_req_wmask", g_wmask, 4'b0010);
    check("sb_req_wdata", g_wdata, 32'hA5A5_A5A5);
    present(mk(1, 0, 3'b001, 32'h52, 0, lh, 5'd11, 1, 2, 32'h9ABC_1234));
    check("lh_wb_data", wb_data, 32'hFFFF_9ABC);
    present(mk(1, 0, 3'b101, 32'h52, 0, lhu, 5'd11, 1, 0, 32'h9ABC_1234));
    check("lhu_wb_data", wb_data, 32'h0000_9ABC);
    present(mk(0, 1, 3'b010, 32'h60, 32'hCAFE_F00D, alu_out, 5'd0, 0, 0, 0));
    check("sw_req_wmask", g_wmask, 4'b1111);
    check("sw_req_wdata", g_wdata, 32'hCAFE_F00D);
    present(mk(1, 0, 3'b010, 32'h64, 0, lw, 5'd12, 1, 1, 32'h1357_2468));
    check("lw_wb_data", wb_data, 32'h1357_2468);
    check("lw_wb_lrf", wb_load_regfile, 1'b1);
    present(mk(1, 0, 3'b010, 32'h68, 0, lw, 5'd0, 1, 0, 32'h7777_0000));
    check("lw_x0_wb_lrf", wb_load_regfile, 1'b0);

    // jal at the top of the address space writing x0
    x = mk(0, 0, 3'b000, 32'h0, 0, pc_plus4, 5'd0, 1, 0, 0);
    x.pc = 32'hFFFF_FFFC;
    present(x);
    check("jal_wb_valid", wb_valid, 1'b1);
    check("jal_wb_data", wb_data, 32'h0000_0000);
    check("jal_wb_lrf", wb_load_regfile, 1'b0);

    step();
    check("idle_wb_valid", wb_valid, 1'b0);
    check("mis_err_sticky", misalign_err, 1'b1);

    // reset while an access is waiting; a late response is ignored
    drive(mk(1, 0, 3'b010, 32'h100, 0, lw, 5'd13, 1, 0, 0));
    step();
    check("rst_acc_req_read", dmem_read, 1'b1);
    step();
    rst = 1'b1; in_valid = 1'b0; in_load = 1'b0;
    step();
    rst = 1'b0;
    check("rst_acc_read", dmem_read, 1'b0);
    check("rst_acc_count", stall_count, 32'd0);
    check("rst_acc_mis", misalign_err, 1'b0);
    dmem_resp = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
    step();
    dmem_resp = 1'b0;
    check("late_resp_wb_valid", wb_valid, 1'b0);
    check("late_resp_read", dmem_read, 1'b0);
    step();
    check("late_resp_wb_valid2", wb_valid, 1'b0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back stage of the pipelined RV32I core. Takes the EX/MEM pipeline-register contents and issues loads and stores to the data cache over a request/response handshake, stalling upstream stages while an access is outstanding. It performs byte/halfword store masking and load extraction/extension, then selects write-back data per `regfilemux_sel_t`. The registered MEM/WB result feeds the register file and the `forward_mem` leg of the forwarding muxes.

## Interface

Parameters:
- CNT_W, 32, width of the stall-cycle performance counter

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX/MEM slot holds a real instruction
- in_load / in_store  in  1 / 1  instruction is a load / store (mutually exclusive)
- in_funct3  in  3  RV32I funct3 (size/sign)
- in_alu_out  in  32  ALU result; also the effective address
- in_rs2  in  32  store data
- in_pc  in  32  instruction PC
- in_u_imm  in  32  U-immediate
- in_br_en  in  1  comparator result
- in_regfilemux_sel  in  4  `regfilemux::regfilemux_sel_t`
- in_rd  in  5  destination register
- in_load_regfile  in  1  instruction writes rd
- dmem_address  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_read / dmem_write  out  1 / 1  request strobes
- dmem_wmask  out  4  byte enables
- dmem_wdata  out  32  store data, lane-aligned
- dmem_rdata  in  32  read word
- dmem_resp  in  1  access complete (one cycle)
- stall_mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- misalign_err  out  1  sticky: misaligned access seen
- wb_valid  out  1  MEM/WB holds a real instruction
- wb_rd  out  5  destination
- wb_data  out  32  write-back value
- wb_load_regfile  out  1  = wb_valid & captured in_load_regfile & (wb_rd != 0)
- stall_count  out  CNT_W  cycles with stall_mem high, wraps

## Operation

- FSM states IDLE, ACCESS. mem_op = in_valid & (in_load | in_store) & aligned.
- Aligned: funct3[1:0]=00 always; 01 needs addr[0]=0; 10 needs addr[1:0]=00.
- IDLE, no mem_op: if in_valid, MEM/WB captures result; misaligned mem op captures wb_valid=1, wb_load_regfile=0, sets misalign_err, no dmem access.
- IDLE, mem_op: stall_mem=1, register request fields, MEM/WB captures bubble (wb_valid=0), go ACCESS.
- ACCESS: dmem_read/dmem_write and address/mask/wdata held constant from registers; stall_mem = ~dmem_resp; bubble captured while waiting. On dmem_resp: capture result (loads use dmem_rdata), go IDLE; upstream advances on the same edge.
- Store mask: sb 0001<<addr[1:0], data {4{rs2[7:0]}}; sh 0011<<{addr[1],0}, data {2{rs2[15:0]}}; sw 1111, data rs2. Loads: wmask 0000.
- wb_data by sel: alu_out; br_en zero-extended; u_imm; lw rdata; pc_plus4 = in_pc+4 (mod 2^32); lb/lbu byte addr[1:0] sign/zero-extended; lh/lhu halfword addr[1] sign/zero-extended. Undefined sel codes -> 0.
- dmem_resp in IDLE is ignored.
- stall_count increments every cycle stall_mem=1, wraps at 2^CNT_W.

## Timing

- Reset: state IDLE; dmem_read, dmem_write, dmem_wmask, wb_valid, wb_load_regfile, misalign_err, stall_mem = 0; wb_rd, wb_data, dmem_address, dmem_wdata, stall_count = 0.
- Reset mid-ACCESS drops the request on the next edge; a late dmem_resp is ignored.
- Non-memory op: in MEM/WB 1 edge after presentation.
- Memory op: request visible 1 cycle after presentation; result in MEM/WB on the edge after dmem_resp; minimum 2 cycles, stall_mem high for 1 + wait cycles.
- stall_mem is combinational from state, in_* and dmem_resp; all other outputs registered.
- Back-to-back memory ops: second op enters its IDLE cycle right after the first's resp edge; no request overlap.

## Test plan

- Reset, then add (alu_out=0x10, sel alu_out, rd=5) -> next cycle wb_valid=1, wb_rd=5, wb_data=0x10, stall_count=0.
- lb addr 0x1003, rdata 0x80FF_1234, resp 3 cycles after request -> dmem_address=0x1000, stall_mem high 4 cycles, wb_data=0xFFFF_FF80; lbu same -> 0x0000_0080.
- sh addr 0x2002, rs2=0xAAAA_BEEF -> dmem_write=1, wmask=1100, wdata=0xBEEF_BEEF, wb_load_regfile=0.
- lw addr 0x3001 -> no dmem_read, misalign_err=1 and stays 1, wb_load_regfile=0.
- rst asserted while ACCESS waiting -> next cycle dmem_read=0, state IDLE; a resp pulse one cycle later produces no wb_valid.
- jal with in_pc=0xFFFF_FFFC, sel pc_plus4, rd=0 -> wb_data=0x0000_0000, wb_load_regfile=0.
